// File: rtl/vga_timing_detect.sv
// rtl/vga_timing_detect.sv - incoming line timing detector: segment measurement, line report, lock; optional VGA_TDET_TOL_EN tolerance match
module vga_timing_detect #(
  parameter int Disp       = 1280,
  parameter int Front      = 48,
  parameter int Sync       = 112,
  parameter int Back       = 248,
  parameter int LOCK_LINES = 4,
  parameter int TOL        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_sync,
  input  logic        i_disp,
  output logic [10:0] o_disp_len,
  output logic [10:0] o_front_len,
  output logic [10:0] o_sync_len,
  output logic [10:0] o_back_len,
  output logic        o_line_valid,
  output logic        o_locked,
  output logic        o_err
);

  localparam logic [10:0] SatVal  = 11'h7FF;
  localparam logic [3:0]  LockVal = 4'(LOCK_LINES);

  if (LOCK_LINES < 1 || LOCK_LINES > 15 || TOL < 0 || TOL > 1023) begin : g_param_check
    $error("vga_timing_detect: LOCK_LINES must be 1..15 and TOL 0..1023");
  end

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_SYNC,
    ST_BACK,
    ST_DISP,
    ST_FRONT
  } state_t;

  state_t      state;
  logic        s_sync, s_disp;
  logic        p_sync, p_disp;
  logic [10:0] seg_cnt;
  logic [10:0] sh_disp, sh_front, sh_sync, sh_back;
  logic        pend;
  logic [3:0]  match_cnt;

  logic        sync_fall, sync_rise, disp_rise, disp_fall;
  logic        illegal;
  logic [10:0] seg_next;
  logic        line_match;

  // A saturated measurement is never accepted, even if it lands inside the window.
  function automatic logic seg_ok(input logic [10:0] len, input int expv);
`ifdef VGA_TDET_TOL_EN
    logic [11:0] l12, lo, hi;
    l12 = {1'b0, len};
    hi  = 12'(expv + TOL);
    lo  = (expv > TOL) ? 12'(expv - TOL) : 12'd0;
    return (len != SatVal) && (l12 >= lo) && (l12 <= hi);
`else
    return (len != SatVal) && (len == 11'(expv));
`endif
  endfunction

  assign sync_fall  = p_sync & ~s_sync;
  assign sync_rise  = ~p_sync & s_sync;
  assign disp_rise  = ~p_disp & s_disp;
  assign disp_fall  = p_disp & ~s_disp;
  assign illegal    = s_disp & ~s_sync & (state != ST_HUNT);
  assign seg_next   = (seg_cnt == SatVal) ? seg_cnt : seg_cnt + 11'd1;
  assign line_match = seg_ok(sh_disp, Disp) && seg_ok(sh_front, Front) &&
                      seg_ok(sh_sync, Sync) && seg_ok(sh_back, Back);

  // Register the raw inputs once and keep the previous sample for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sync <= 1'b0;
      s_disp <= 1'b0;
      p_sync <= 1'b0;
      p_disp <= 1'b0;
    end else begin
      s_sync <= i_sync;
      s_disp <= i_disp;
      p_sync <= s_sync;
      p_disp <= s_disp;
    end
  end

  // Segment tracker, shadow length capture, line report and lock accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_HUNT;
      seg_cnt      <= 11'd0;
      sh_disp      <= 11'd0;
      sh_front     <= 11'd0;
      sh_sync      <= 11'd0;
      sh_back      <= 11'd0;
      pend         <= 1'b0;
      match_cnt    <= 4'd0;
      o_disp_len   <= 11'd0;
      o_front_len  <= 11'd0;
      o_sync_len   <= 11'd0;
      o_back_len   <= 11'd0;
      o_line_valid <= 1'b0;
      o_locked     <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_err        <= 1'b0;
      o_line_valid <= 1'b0;
      pend         <= 1'b0;
      seg_cnt      <= seg_next;

      // Publish the completed line one cycle after FRONT closed; all four lengths move together.
      if (pend) begin
        o_disp_len   <= sh_disp;
        o_front_len  <= sh_front;
        o_sync_len   <= sh_sync;
        o_back_len   <= sh_back;
        o_line_valid <= 1'b1;
        if (line_match) begin
          if (match_cnt != LockVal) begin
            match_cnt <= match_cnt + 4'd1;
            o_locked  <= ((match_cnt + 4'd1) == LockVal);
          end else begin
            o_locked <= 1'b1;
          end
        end else begin
          match_cnt <= 4'd0;
          o_locked  <= 1'b0;
        end
      end

      // The illegal combination outranks every edge seen in the same sample.
      if (illegal) begin
        o_err     <= 1'b1;
        match_cnt <= 4'd0;
        o_locked  <= 1'b0;
        state     <= ST_HUNT;
      end else begin
        case (state)
          ST_HUNT: begin
            if (sync_fall) begin
              seg_cnt <= 11'd1;
              state   <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (sync_rise) begin
              sh_sync <= seg_cnt;
              seg_cnt <= 11'd1;
              state   <= ST_BACK;
            end
          end
          ST_BACK: begin
            if (sync_fall) begin
              // Sync restarted before any active video: drop the line, resync on this pulse.
              o_err     <= 1'b1;
              match_cnt <= 4'd0;
              o_locked  <= 1'b0;
              seg_cnt   <= 11'd1;
              state     <= ST_SYNC;
            end else if (disp_rise) begin
              sh_back <= seg_cnt;
              seg_cnt <= 11'd1;
              state   <= ST_DISP;
            end
          end
          ST_DISP: begin
            if (disp_fall) begin
              sh_disp <= seg_cnt;
              seg_cnt <= 11'd1;
              state   <= ST_FRONT;
            end
          end
          ST_FRONT: begin
            if (sync_fall) begin
              sh_front <= seg_cnt;
              seg_cnt  <= 11'd1;
              pend     <= 1'b1;
              state    <= ST_SYNC;
            end else if (disp_rise) begin
              o_err     <= 1'b1;
              match_cnt <= 4'd0;
              o_locked  <= 1'b0;
              state     <= ST_HUNT;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_detect.sv
// tb/tb_vga_timing_detect.sv - randomized line stimulus against a line-level reference model
module tb_vga_timing_detect;

  localparam int DISP  = 1280;
  localparam int FRONT = 48;
  localparam int SYNC  = 112;
  localparam int BACK  = 248;
  localparam int LOCKN = 4;
  localparam int TOLV  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_sync = 1'b1;
  logic        i_disp = 1'b0;
  logic [10:0] o_disp_len, o_front_len, o_sync_len, o_back_len;
  logic        o_line_valid, o_locked, o_err;

  vga_timing_detect dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sync       (i_sync),
    .i_disp       (i_disp),
    .o_disp_len   (o_disp_len),
    .o_front_len  (o_front_len),
    .o_sync_len   (o_sync_len),
    .o_back_len   (o_back_len),
    .o_line_valid (o_line_valid),
    .o_locked     (o_locked),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned cyc;
    int d, f, s, b;
    bit locked;
  } rep_t;

  rep_t        exp_q[$];
  int unsigned err_q[$];

  // line-level model state
  bit tracking = 0;
  int consec   = 0;
  int last_d, last_f, last_s, last_b;

  // expected held output values
  int mon_d = 0, mon_f = 0, mon_s = 0, mon_b = 0;
  bit mon_locked = 0;
  bit mon_en = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int sat(input int n);
    return (n > 2047) ? 2047 : n;
  endfunction

  function automatic bit near(input int len, input int expv);
`ifdef VGA_TDET_TOL_EN
    return (len != 2047) && (len >= expv - TOLV) && (len <= expv + TOLV);
`else
    return len == expv;
`endif
  endfunction

  task automatic drive(input logic s, input logic d, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      i_sync = s;
      i_disp = d;
    end
  endtask

  // One line: SYNC, BACK, DISP, FRONT. err_at >= 0 injects disp-during-sync; stop_d > 0 cuts DISP short.
  task automatic drive_line(input int s, input int b, input int d, input int f,
                            input int err_at, input int stop_d);
    rep_t r;
    @(posedge clk);
    #1;
    i_sync = 1'b0;
    i_disp = 1'b0;
    if (tracking) begin
      r.cyc = cyc + 3;
      r.d = last_d; r.f = last_f; r.s = last_s; r.b = last_b;
      if (near(last_d, DISP) && near(last_f, FRONT) && near(last_s, SYNC) && near(last_b, BACK))
        consec++;
      else
        consec = 0;
      r.locked = (consec >= LOCKN);
      exp_q.push_back(r);
    end
    tracking = 1;
    last_s = sat(s); last_b = sat(b); last_d = sat(d); last_f = sat(f);
    if (err_at >= 0) begin
      drive(1'b0, 1'b0, err_at);
      @(posedge clk);
      #1;
      i_sync = 1'b0;
      i_disp = 1'b1;
      err_q.push_back(cyc + 2);
      tracking = 0;
      consec = 0;
      drive(1'b1, 1'b0, 10);
      return;
    end
    drive(1'b0, 1'b0, s - 1);
    drive(1'b1, 1'b0, b);
    if (stop_d > 0) begin
      drive(1'b1, 1'b1, stop_d);
      return;
    end
    drive(1'b1, 1'b1, d);
    drive(1'b1, 1'b0, f);
  endtask

  task automatic nominal(input int n);
    repeat (n) drive_line(SYNC, BACK, DISP, FRONT, -1, 0);
  endtask

  function automatic int pick(input int nom);
    if ($urandom_range(0, 3) == 0) return nom + int'($urandom_range(0, 6)) - 3;
    return nom;
  endfunction

  // Per-cycle comparison of every output against the model's expected state.
  always @(negedge clk) begin
    rep_t e;
    bit   v_exp;
    if (rst_n && mon_en) begin
      v_exp = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        v_exp = 1'b1;
        mon_d = e.d; mon_f = e.f; mon_s = e.s; mon_b = e.b;
        mon_locked = e.locked;
      end
      check("line_valid", o_line_valid, v_exp);
      if (err_q.size() > 0 && err_q[0] == cyc) begin
        void'(err_q.pop_front());
        check("err_pulse", o_err, 1);
        mon_locked = 1'b0;
      end else begin
        check("err_quiet", o_err, 0);
      end
      check("disp_len", o_disp_len, mon_d);
      check("front_len", o_front_len, mon_f);
      check("sync_len", o_sync_len, mon_s);
      check("back_len", o_back_len, mon_b);
      check("locked", o_locked, mon_locked);
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_disp"}, o_disp_len, 0);
    check({tag, "_front"}, o_front_len, 0);
    check({tag, "_sync"}, o_sync_len, 0);
    check({tag, "_back"}, o_back_len, 0);
    check({tag, "_valid"}, o_line_valid, 0);
    check({tag, "_locked"}, o_locked, 0);
    check({tag, "_err"}, o_err, 0);
  endtask

  initial begin
    #(1500000 * 10);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, b, d, f;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    drive(1'b1, 1'b0, 10);

    // nominal lines until lock
    nominal(6);
    // one long front porch, then relock
    drive_line(SYNC, BACK, DISP, 49, -1, 0);
    nominal(5);
    // back porch at the tolerance edge and just past it
    drive_line(SYNC, 250, DISP, FRONT, -1, 0);
    nominal(1);
    drive_line(SYNC, 251, DISP, FRONT, -1, 0);
    nominal(4);
    // disp asserted during sync
    drive_line(SYNC, BACK, DISP, FRONT, 50, 0);
    // overlong active period saturates
    nominal(1);
    drive_line(SYNC, BACK, 3000, FRONT, -1, 0);
    nominal(2);
    // randomized lines: near-nominal or short arbitrary
    repeat (10) begin
      if ($urandom_range(0, 2) == 0) begin
        s = pick(SYNC); b = pick(BACK); d = pick(DISP); f = pick(FRONT);
      end else begin
        s = $urandom_range(1, 60); b = $urandom_range(1, 60);
        d = $urandom_range(1, 60); f = $urandom_range(1, 60);
      end
      drive_line(s, b, d, f, -1, 0);
    end
    // lock, then reset in the middle of DISP
    nominal(5);
    drive_line(SYNC, BACK, DISP, FRONT, -1, 500);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    exp_q.delete();
    err_q.delete();
    tracking = 0;
    consec = 0;
    mon_d = 0; mon_f = 0; mon_s = 0; mon_b = 0;
    mon_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 10);
    nominal(6);
    drive(1'b1, 1'b0, 20);

    check("pending_reports", exp_q.size(), 0);
    check("pending_errors", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
